// File: rtl/hilo_wb_arb.sv
// hilo_wb_arb: HI/LO writeback stage behind the multiplier.
// Multiplier results cannot stall, so they land in a small FIFO. The FIFO
// head and the iterative divider share one registered writeback port. The
// divider is forced to win after STARVE_MAX consecutive lost cycles.
//
// Divider handshake: div_valid is held by the divider until accepted; div_ready
// is the combinational grant (it may depend on div_valid), and a transfer
// happens in any cycle where div_valid && div_ready are both high.
//
// Observable state for checkers: count, head, tail and starve_cnt are plain
// registers at the top level.

`ifndef LG_ROB_ENTRIES
`define LG_ROB_ENTRIES 6
`endif
`ifndef LG_HILO_PRF_ENTRIES
`define LG_HILO_PRF_ENTRIES 4
`endif

module hilo_wb_arb #(
  parameter int DEPTH        = 8,
  parameter int STARVE_MAX   = 3,
  parameter int MUL_INFLIGHT = 5
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            mul_complete,
  input  logic [`LG_ROB_ENTRIES-1:0]      mul_rob_ptr,
  input  logic                            mul_hilo_val,
  input  logic [`LG_HILO_PRF_ENTRIES-1:0] mul_hilo_ptr,
  input  logic [63:0]                     mul_y,
  input  logic                            div_valid,
  output logic                            div_ready,
  input  logic [`LG_ROB_ENTRIES-1:0]      div_rob_ptr,
  input  logic [`LG_HILO_PRF_ENTRIES-1:0] div_hilo_ptr,
  input  logic [63:0]                     div_y,
  output logic                            mul_issue_ok,
  output logic                            wb_valid,
  output logic [`LG_ROB_ENTRIES-1:0]      wb_rob_ptr,
  output logic                            wb_hilo_val,
  output logic [`LG_HILO_PRF_ENTRIES-1:0] wb_hilo_ptr,
  output logic [63:0]                     wb_y,
  output logic                            overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam int RW = `LG_ROB_ENTRIES;
  localparam int HW = `LG_HILO_PRF_ENTRIES;
  localparam logic [PW:0]   FULL_CNT   = (PW+1)'(DEPTH);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef struct packed {
    logic [RW-1:0] rob_ptr;
    logic          hilo_val;
    logic [HW-1:0] hilo_ptr;
    logic [63:0]   y;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;
  logic [SW-1:0] starve_cnt;

  entry_t head_entry;
  logic   fifo_avail;
  logic   grant_div;
  logic   grant_mul;
  logic   enq;
  logic   deq;
  logic   drop;

  // Arbitration and FIFO control, all from registered state plus div_valid.
  always_comb begin
    head_entry = mem[head];
    fifo_avail = (count != '0);
    grant_div  = reset && div_valid && (!fifo_avail || (starve_cnt == STARVE_LIM));
    grant_mul  = reset && fifo_avail && !grant_div;
    deq        = grant_mul;
    // A full FIFO still accepts a result if the head leaves in the same cycle.
    enq        = reset && mul_complete && ((count != FULL_CNT) || deq);
    drop       = reset && mul_complete && (count == FULL_CNT) && !deq;
  end

  assign div_ready    = grant_div;
  // Credit uses registered count only; upstream tracks its own in-flight ops.
  assign mul_issue_ok = reset && ((DEPTH - int'(count)) > MUL_INFLIGHT);

  // FIFO storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[tail] <= '{rob_ptr: mul_rob_ptr, hilo_val: mul_hilo_val,
                     hilo_ptr: mul_hilo_ptr, y: mul_y};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally, count decides full/empty.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + PW'(1);
      if (deq) head <= head + PW'(1);
      count <= count + (PW+1)'(enq) - (PW+1)'(deq);
    end
  end

  // Divider starvation counter: cleared on transfer or idle, saturating otherwise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!div_valid || grant_div) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Sticky overflow flag: a multiplier result arrived with no room for it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

  // Registered writeback port; fields hold their value when nothing is granted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_valid    <= 1'b0;
      wb_rob_ptr  <= '0;
      wb_hilo_val <= 1'b0;
      wb_hilo_ptr <= '0;
      wb_y        <= '0;
    end else begin
      wb_valid <= grant_div || grant_mul;
      if (grant_div) begin
        wb_rob_ptr  <= div_rob_ptr;
        wb_hilo_val <= 1'b1;
        wb_hilo_ptr <= div_hilo_ptr;
        wb_y        <= div_y;
      end else if (grant_mul) begin
        wb_rob_ptr  <= head_entry.rob_ptr;
        wb_hilo_val <= head_entry.hilo_val;
        wb_hilo_ptr <= head_entry.hilo_ptr;
        wb_y        <= head_entry.y;
      end
    end
  end

endmodule

// File: tb/tb_hilo_wb_arb.sv
// tb_hilo_wb_arb: directed vector table plus multi-cycle sequences for the
// HI/LO writeback arbiter, checked against a cycle-level reference model.

`ifndef LG_ROB_ENTRIES
`define LG_ROB_ENTRIES 6
`endif
`ifndef LG_HILO_PRF_ENTRIES
`define LG_HILO_PRF_ENTRIES 4
`endif

module tb_hilo_wb_arb;

  localparam int DEPTH        = 8;
  localparam int STARVE_MAX   = 3;
  localparam int MUL_INFLIGHT = 5;
  localparam int RW = `LG_ROB_ENTRIES;
  localparam int HW = `LG_HILO_PRF_ENTRIES;

  typedef struct packed {
    logic [RW-1:0] rob_ptr;
    logic          hilo_val;
    logic [HW-1:0] hilo_ptr;
    logic [63:0]   y;
  } entry_t;

  typedef struct {
    logic          mul_c;
    logic [RW-1:0] m_rob;
    logic          m_hv;
    logic [HW-1:0] m_hp;
    logic [63:0]   m_y;
    logic          div_v;
    logic [RW-1:0] d_rob;
    logic [HW-1:0] d_hp;
    logic [63:0]   d_y;
    logic          exp_ready;
    int            exp_lat;
    logic          exp_hv;
    logic [RW-1:0] exp_rob;
    logic [63:0]   exp_y;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          mul_complete;
  logic [RW-1:0] mul_rob_ptr;
  logic          mul_hilo_val;
  logic [HW-1:0] mul_hilo_ptr;
  logic [63:0]   mul_y;
  logic          div_valid;
  logic          div_ready;
  logic [RW-1:0] div_rob_ptr;
  logic [HW-1:0] div_hilo_ptr;
  logic [63:0]   div_y;
  logic          mul_issue_ok;
  logic          wb_valid;
  logic [RW-1:0] wb_rob_ptr;
  logic          wb_hilo_val;
  logic [HW-1:0] wb_hilo_ptr;
  logic [63:0]   wb_y;
  logic          overflow;

  always #5 clk = ~clk;

  hilo_wb_arb #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX), .MUL_INFLIGHT(MUL_INFLIGHT)) dut (
    .clk(clk), .reset(reset),
    .mul_complete(mul_complete), .mul_rob_ptr(mul_rob_ptr), .mul_hilo_val(mul_hilo_val),
    .mul_hilo_ptr(mul_hilo_ptr), .mul_y(mul_y),
    .div_valid(div_valid), .div_ready(div_ready), .div_rob_ptr(div_rob_ptr),
    .div_hilo_ptr(div_hilo_ptr), .div_y(div_y),
    .mul_issue_ok(mul_issue_ok),
    .wb_valid(wb_valid), .wb_rob_ptr(wb_rob_ptr), .wb_hilo_val(wb_hilo_val),
    .wb_hilo_ptr(wb_hilo_ptr), .wb_y(wb_y), .overflow(overflow)
  );

  // ---------------- reference model / scoreboard state ----------------
  entry_t      model_q[$];
  entry_t      exp_q[$];
  int          starve;
  logic        model_ovf;
  int          cyc;
  int          n_checks;
  int          n_err;
  logic        last_m, last_gdiv, last_gmul, last_div_ready;
  int          cap_cyc;
  logic [RW-1:0] cap_rob;
  logic        cap_hv;
  logic [63:0] cap_y;
  logic [RW-1:0] log_rob[$];
  logic [63:0] log_y[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    mul_complete = 1'b0; mul_rob_ptr = '0; mul_hilo_val = 1'b0; mul_hilo_ptr = '0; mul_y = '0;
    div_valid = 1'b0; div_rob_ptr = '0; div_hilo_ptr = '0; div_y = '0;
  endtask

  // One clock cycle: check combinational outputs against the model, push the
  // expected writeback, advance the model at the edge, then check registered outputs.
  task automatic step();
    logic   m, gdiv, gmul, rst_e, mc, dv;
    entry_t e, ne;
    #1;
    m    = (model_q.size() != 0);
    gdiv = reset && div_valid && (!m || (starve == STARVE_MAX));
    gmul = reset && m && !gdiv;
    chk("div_ready", 64'(div_ready), 64'(gdiv));
    chk("mul_issue_ok", 64'(mul_issue_ok), 64'(reset && ((DEPTH - model_q.size()) > MUL_INFLIGHT)));
    last_m = m; last_gdiv = gdiv; last_gmul = gmul; last_div_ready = div_ready;
    if (gdiv) begin
      e.rob_ptr = div_rob_ptr; e.hilo_val = 1'b1; e.hilo_ptr = div_hilo_ptr; e.y = div_y;
      exp_q.push_back(e);
    end else if (gmul) begin
      exp_q.push_back(model_q[0]);
    end
    rst_e = reset; mc = mul_complete; dv = div_valid;
    ne.rob_ptr = mul_rob_ptr; ne.hilo_val = mul_hilo_val; ne.hilo_ptr = mul_hilo_ptr; ne.y = mul_y;
    @(posedge clk);
    cyc++;
    if (!rst_e) begin
      model_q.delete(); exp_q.delete(); starve = 0; model_ovf = 1'b0;
    end else begin
      if (gmul) void'(model_q.pop_front());
      if (mc) begin
        if (model_q.size() < DEPTH) model_q.push_back(ne);
        else model_ovf = 1'b1;
      end
      if (!dv || gdiv) starve = 0;
      else if (starve < STARVE_MAX) starve++;
    end
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("wb_valid", 64'(wb_valid), 64'd1);
      chk("wb_rob_ptr", 64'(wb_rob_ptr), 64'(e.rob_ptr));
      chk("wb_hilo_val", 64'(wb_hilo_val), 64'(e.hilo_val));
      chk("wb_hilo_ptr", 64'(wb_hilo_ptr), 64'(e.hilo_ptr));
      chk("wb_y", wb_y, e.y);
    end else begin
      chk("wb_valid_idle", 64'(wb_valid), 64'd0);
    end
    chk("overflow", 64'(overflow), 64'(model_ovf));
    chk("count", 64'(dut.count), 64'(model_q.size()));
    if (wb_valid) begin
      log_rob.push_back(wb_rob_ptr);
      log_y.push_back(wb_y);
      if (cap_cyc < 0) begin
        cap_cyc = cyc; cap_rob = wb_rob_ptr; cap_hv = wb_hilo_val; cap_y = wb_y;
      end
    end
  endtask

  task automatic idle(input int n);
    clear_inputs();
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  // Continuous multiplier traffic with the divider always pending.
  task automatic drive_traffic(input int k, input int c);
    mul_complete = 1'b1;
    mul_rob_ptr  = RW'(k);
    mul_hilo_val = k[0];
    mul_hilo_ptr = HW'(k);
    mul_y        = {16'hF111, 16'($urandom_range(0, 65535)), 32'(k)};
    div_valid    = 1'b1;
    div_rob_ptr  = RW'(40);
    div_hilo_ptr = HW'($urandom_range(0, (1 << HW) - 1));
    div_y        = {32'hD1D1_0000, 32'(c)};
  endtask

  // ---------------- test ----------------
  vec_t vecs[5];

  initial begin
    int t0, cont, won_at, k, pre, nmul;
    logic seen2, seen3, pair_done, ovf_seen, found, div_done, got4;
    logic [63:0] cur_y, dropped_y;

    vecs[0] = '{1'b1, RW'(5),  1'b1, HW'(3), 64'h0000_0001_FFFF_FFFE, 1'b0, RW'(0),  HW'(0),  64'h0,
                1'b0, 2, 1'b1, RW'(5),  64'h0000_0001_FFFF_FFFE};
    vecs[1] = '{1'b0, RW'(0),  1'b0, HW'(0), 64'h0,                   1'b1, RW'(9),  HW'(2),  64'h7,
                1'b1, 1, 1'b1, RW'(9),  64'h7};
    vecs[2] = '{1'b1, RW'(12), 1'b0, HW'(1), 64'h1234_5678_9ABC_DEF0, 1'b0, RW'(0),  HW'(0),  64'h0,
                1'b0, 2, 1'b0, RW'(12), 64'h1234_5678_9ABC_DEF0};
    vecs[3] = '{1'b1, RW'(20), 1'b1, HW'(4), 64'hAAAA,                1'b1, RW'(21), HW'(6),  64'hBBBB,
                1'b1, 1, 1'b1, RW'(21), 64'hBBBB};
    vecs[4] = '{1'b0, RW'(0),  1'b0, HW'(0), 64'h0,                   1'b1, RW'(63), HW'(15), 64'hFFFF_FFFF_FFFF_FFFF,
                1'b1, 1, 1'b1, RW'(63), 64'hFFFF_FFFF_FFFF_FFFF};

    n_checks = 0; n_err = 0; cyc = 0; starve = 0; model_ovf = 1'b0; cap_cyc = -1;

    // Reset with the divider pending: handshake and credit must stay low.
    clear_inputs();
    reset = 1'b0;
    div_valid = 1'b1;
    step();
    step();
    chk("reset_wb_valid", 64'(wb_valid), 64'd0);
    chk("reset_overflow", 64'(overflow), 64'd0);
    chk("reset_count", 64'(dut.count), 64'd0);
    reset = 1'b1;
    idle(1);

    // Table of isolated transactions from an empty FIFO.
    foreach (vecs[i]) begin
      idle(3);
      cap_cyc = -1;
      mul_complete = vecs[i].mul_c; mul_rob_ptr = vecs[i].m_rob; mul_hilo_val = vecs[i].m_hv;
      mul_hilo_ptr = vecs[i].m_hp;  mul_y = vecs[i].m_y;
      div_valid = vecs[i].div_v; div_rob_ptr = vecs[i].d_rob; div_hilo_ptr = vecs[i].d_hp; div_y = vecs[i].d_y;
      t0 = cyc;
      step();
      chk($sformatf("vec%0d_div_ready", i), 64'(last_div_ready), 64'(vecs[i].exp_ready));
      idle(3);
      chk($sformatf("vec%0d_latency", i), 64'(cap_cyc - t0), 64'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_rob", i), 64'(cap_rob), 64'(vecs[i].exp_rob));
      chk($sformatf("vec%0d_hilo_val", i), 64'(cap_hv), 64'(vecs[i].exp_hv));
      chk($sformatf("vec%0d_y", i), cap_y, vecs[i].exp_y);
      chk($sformatf("vec%0d_count_empty", i), 64'(dut.count), 64'd0);
    end

    // Starvation: ten back-to-back multiplies, divider pending from cycle 1.
    idle(2);
    log_rob.delete(); log_y.delete();
    cont = 0; won_at = 0; div_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mul_complete = 1'b1; mul_rob_ptr = RW'(16 + i); mul_hilo_val = 1'b1;
      mul_hilo_ptr = HW'(i); mul_y = {32'h5A5A_0000, 32'(i)};
      div_valid = (i > 0) && !div_done; div_rob_ptr = RW'(40); div_hilo_ptr = HW'(9);
      div_y = 64'($urandom_range(0, 1000));
      step();
      if (last_m && div_valid) cont++;
      if (last_gdiv) begin div_done = 1'b1; won_at = cont; end
    end
    idle(4);
    chk("starve_win_cycle", 64'(won_at), 64'd4);
    nmul = 0;
    foreach (log_rob[i]) begin
      if (log_rob[i] != RW'(40)) begin
        chk($sformatf("mul_order_%0d", nmul), 64'(log_rob[i]), 64'(16 + nmul));
        nmul++;
      end
    end
    chk("mul_writeback_count", 64'(nmul), 64'd10);
    chk("starve_no_overflow", 64'(overflow), 64'd0);

    // Credit, full with enqueue+dequeue, then overflow.
    do_reset();
    log_rob.delete(); log_y.delete();
    k = 0; seen2 = 1'b0; seen3 = 1'b0; pair_done = 1'b0; ovf_seen = 1'b0; dropped_y = '0;
    for (int c = 0; c < 150; c++) begin
      drive_traffic(k, c);
      pre = model_q.size();
      cur_y = mul_y;
      step();
      k++;
      if (model_q.size() == 2 && !seen2) begin seen2 = 1'b1; chk("credit_at_2", 64'(mul_issue_ok), 64'd1); end
      if (model_q.size() == 3 && !seen3) begin seen3 = 1'b1; chk("credit_at_3", 64'(mul_issue_ok), 64'd0); end
      if (pre == DEPTH && last_gmul && !pair_done) begin
        pair_done = 1'b1;
        chk("full_enq_deq_count", 64'(dut.count), 64'(DEPTH));
        chk("full_enq_deq_ovf", 64'(overflow), 64'd0);
      end
      if (pre == DEPTH && last_gdiv) begin
        ovf_seen = 1'b1;
        dropped_y = cur_y;
        chk("overflow_set", 64'(overflow), 64'd1);
        break;
      end
    end
    chk("credit_seen", 64'({seen2, seen3}), 64'b11);
    chk("full_pair_reached", 64'(pair_done), 64'd1);
    chk("overflow_reached", 64'(ovf_seen), 64'd1);
    idle(14);
    chk("overflow_sticky", 64'(overflow), 64'd1);
    chk("drained_count", 64'(dut.count), 64'd0);
    found = 1'b0;
    foreach (log_y[i]) if (ovf_seen && log_y[i] == dropped_y) found = 1'b1;
    chk("dropped_not_written", 64'(found), 64'd0);

    // Reset mid-stream with four entries queued.
    do_reset();
    chk("overflow_cleared", 64'(overflow), 64'd0);
    got4 = 1'b0;
    for (int c = 0; c < 60 && !got4; c++) begin
      drive_traffic(c + 100, c);
      step();
      got4 = (model_q.size() == 4);
    end
    chk("four_queued", 64'(got4), 64'd1);
    reset = 1'b0;
    mul_complete = 1'b1;
    div_valid = 1'b1;
    step();
    reset = 1'b1;
    clear_inputs();
    chk("rst_mid_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_mid_count", 64'(dut.count), 64'd0);
    #1;
    chk("rst_mid_issue_ok", 64'(mul_issue_ok), 64'd1);
    chk("rst_mid_div_ready_idle", 64'(div_ready), 64'd0);
    step();
    chk("rst_mid_no_wb", 64'(wb_valid), 64'd0);
    div_valid = 1'b1; div_rob_ptr = RW'(33); div_hilo_ptr = HW'(5); div_y = 64'h55;
    step();
    chk("rst_mid_div_ready", 64'(last_div_ready), 64'd1);
    idle(3);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Bound on total run time in case a sequence stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hilo_wb_arb.md
Name: hilo_wb_arb

Overview:
- Writeback stage directly downstream of the 32x32 multiplier; also accepts completions from the iterative divider.
- Buffers multiplier results, which are fixed-latency and cannot stall, in a small FIFO.
- Arbitrates between the FIFO head and the divider (ready/valid) for a single registered HI/LO PRF write port plus ROB completion port.
- Returns an issue-credit signal to multiplier issue logic so the FIFO never overflows.

Parameters:
- DEPTH, 8, multiplier result FIFO entries (power of 2, >=2).
- STARVE_MAX, 3, consecutive cycles the divider may lose arbitration before it is forced to win.
- MUL_INFLIGHT, 5, max multiplies in flight between issue and mul_complete; used for the credit check.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (asserted when 0)
- mul_complete  in  1  multiplier result valid this cycle
- mul_rob_ptr  in  `LG_ROB_ENTRIES  ROB tag of the multiplier result
- mul_hilo_val  in  1  multiplier result writes HI/LO
- mul_hilo_ptr  in  `LG_HILO_PRF_ENTRIES  destination HI/LO PRF entry
- mul_y  in  64  product {hi,lo}
- div_valid  in  1  divider result pending
- div_ready  out  1  divider result accepted this cycle
- div_rob_ptr  in  `LG_ROB_ENTRIES  divider ROB tag
- div_hilo_ptr  in  `LG_HILO_PRF_ENTRIES  divider destination
- div_y  in  64  {remainder,quotient}
- mul_issue_ok  out  1  upstream may issue a multiply this cycle
- wb_valid  out  1  writeback/complete valid
- wb_rob_ptr  out  `LG_ROB_ENTRIES  completing ROB tag
- wb_hilo_val  out  1  HI/LO PRF write enable
- wb_hilo_ptr  out  `LG_HILO_PRF_ENTRIES  HI/LO PRF write address
- wb_y  out  64  HI/LO write data
- overflow  out  1  sticky error: multiplier result dropped

Behaviour:
- Reset (reset==0 at posedge):
  - FIFO head/tail/count <= 0; starve_cnt <= 0.
  - All wb_* <= 0; overflow <= 0.
  - div_ready and mul_issue_ok are forced to 0 while reset==0.
- FIFO:
  - Entry = {rob_ptr, hilo_val, hilo_ptr, y}.
  - Enqueue at posedge when mul_complete==1.
  - No bypass: an entry written at edge N is first eligible for arbitration in cycle N+1.
- Arbitration (combinational, from registered state):
  - M = (count!=0); D = div_valid.
  - M only -> grant FIFO head.
  - D only -> grant divider.
  - Both -> grant divider iff starve_cnt==STARVE_MAX, else grant FIFO head.
- div_ready = divider granted; it may depend combinationally on div_valid. Transfer occurs when div_valid && div_ready.
- starve_cnt:
  - Resets to 0 on a divider transfer or when div_valid==0.
  - Increments, saturating at STARVE_MAX, when div_valid && !div_ready.
- Output register: one cycle after a grant, wb_valid=1 with the granted fields.
  - Divider grant: wb_hilo_val=1.
  - Mul grant: wb_hilo_val = stored hilo_val.
  - No grant: wb_valid=0, other wb_* hold their previous values.
- Latency:
  - Multiplier result: min 2 cycles from mul_complete to wb_valid.
  - Divider: 1 cycle from transfer to wb_valid.
- Throughput: one writeback per cycle.
- Count update: count_next = count + enq - deq. Simultaneous enqueue and dequeue when full is legal; count stays DEPTH.
- Overflow:
  - Condition: mul_complete while count==DEPTH and no dequeue that cycle.
  - The entry is dropped, FIFO is unchanged, and overflow sets and stays set until reset.
- mul_issue_ok = (DEPTH - count) > MUL_INFLIGHT, using registered count. Upstream alone owns in-flight tracking.
- Pointer wrap: head and tail are log2(DEPTH) bits and wrap naturally; full/empty is decided by count, not pointer compare.
- Reset mid-operation: FIFO contents are discarded, and no wb_valid occurs in the cycle after reset deasserts.

Test Plan:
- Single multiply:
  - Stimulus: mul_complete=1 at cycle 0, rob_ptr=5, hilo_ptr=3, y=64'h0000_0001_FFFF_FFFE, div idle.
  - Required: wb_valid=1 at cycle 2 with those exact fields; count returns to 0.
- Divider alone:
  - Stimulus: div_valid=1, rob_ptr=9, y=64'h7.
  - Required: div_ready=1 same cycle; wb_valid=1 next cycle with wb_hilo_val=1 and wb_y=7.
- Starvation:
  - Stimulus: mul_complete every cycle for 10 cycles while div_valid held high.
  - Required: divider wins exactly on the 4th cycle of contention (STARVE_MAX=3); multiplier order preserved in wb_rob_ptr; no overflow.
- Credit and full:
  - Stimulus: fill FIFO to 3 entries with the divider forced to win.
  - Required: mul_issue_ok drops to 0 once free entries <=5.
  - Stimulus: push to DEPTH=8 with no dequeue, then one more mul_complete.
  - Required: overflow=1 and stays 1; the 9th result is never written back.
- Full with simultaneous enqueue/dequeue:
  - Stimulus: count==8 and a mul grant in the same cycle as mul_complete.
  - Required: count stays 8; overflow stays 0.
- Reset mid-stream:
  - Stimulus: 4 entries queued, reset=0 for one cycle.
  - Required: wb_valid=0 and count=0 afterwards; mul_issue_ok=1 and div_ready follows div_valid after reset deasserts.
